// File: rtl/imem_loader_if.sv
// Byte stream handshake into the instruction memory loader.
// The master (upstream source) drives valid/data and the slave (the loader) drives ready.
interface imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte stream to instruction memory writer.
// Holds the CPU in reset until a complete, checksum-verified program is in memory.
module imem_loader #(
  parameter int MEMORY_SIZE = 32
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bs,
  output logic          wr_en,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  localparam int IDX_W = $clog2(MEMORY_SIZE) + 1;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state_reg, state_next;
  logic [7:0]         len_lo_reg;
  logic [IDX_W-1:0]   n_words_reg;
  logic [IDX_W-1:0]   word_idx_reg;
  logic [1:0]         byte_cnt_reg;
  logic [7:0]         csum_reg;
  logic               wr_en_reg;
  logic [31:0]        wr_addr_reg;
  logic [31:0]        wr_data_reg;

  logic               accept;
  logic [15:0]        len_full;
  logic               len_too_big;
  logic               word_done;
  logic               last_word;

  assign accept      = bs.byte_valid && bs.byte_ready;
  assign len_full    = {bs.byte_data, len_lo_reg};
  assign len_too_big = 32'(len_full) > 32'(MEMORY_SIZE);
  assign word_done   = (byte_cnt_reg == 2'd3);
  assign last_word   = ((word_idx_reg + IDX_W'(1)) == n_words_reg);

  // Lower three bytes of the word under assembly; the 4th byte goes straight to wr_data.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg <= 8'h00;
        end else if (accept && state_reg == S_DATA && byte_cnt_reg == 2'(gi)) begin
          lane_reg <= bs.byte_data;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_LEN_LO: if (accept) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_too_big)         state_next = S_ERROR;
          else if (len_full == '0) state_next = S_CHECK;
          else                     state_next = S_DATA;
        end
      end
      S_DATA:  if (accept && word_done && last_word) state_next = S_CHECK;
      S_CHECK: begin
        if (accept) state_next = (bs.byte_data == csum_reg) ? S_DONE : S_ERROR;
      end
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_LEN_LO;
      len_lo_reg   <= 8'h00;
      n_words_reg  <= '0;
      word_idx_reg <= '0;
      byte_cnt_reg <= 2'd0;
      csum_reg     <= 8'h00;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= 32'h0;
      wr_data_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      wr_en_reg <= 1'b0;
      if (accept) begin
        case (state_reg)
          S_LEN_LO: len_lo_reg  <= bs.byte_data;
          S_LEN_HI: n_words_reg <= len_full[IDX_W-1:0];
          S_DATA: begin
            csum_reg     <= csum_reg ^ bs.byte_data;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (word_done) begin
              wr_en_reg    <= 1'b1;
              wr_data_reg  <= {bs.byte_data, g_lane[2].lane_reg,
                               g_lane[1].lane_reg, g_lane[0].lane_reg};
              wr_addr_reg  <= 32'({word_idx_reg, 2'b00});
              word_idx_reg <= word_idx_reg + IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bs.byte_ready = (state_reg != S_DONE) && (state_reg != S_ERROR);
  assign wr_en         = wr_en_reg;
  assign wr_addr       = wr_addr_reg;
  assign wr_data       = wr_data_reg;
  assign cpu_hold      = (state_reg != S_DONE);
  assign done          = (state_reg == S_DONE);
  assign error         = (state_reg == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frame table, hand sequences, random frames.
// Inputs are driven and outputs sampled on the falling edge.
module tb_imem_loader;
  localparam int MEM = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;
  logic        cpu_hold, done, error;

  always #5 clk = ~clk;

  imem_loader_if bs();

  imem_loader #(.MEMORY_SIZE(MEM)) dut (
    .clk      (clk),
    .rst      (rst),
    .bs       (bs),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  logic [7:0]  frame_q[$];
  logic [31:0] exp_q[$];

  typedef struct packed {
    int          off;
    int          n;
    int          gap_max;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] stim[23];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: records every strobe and confirms the stream is not stalled by it.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      got_cyc.push_back(cyc);
      chk("ready_during_write", {31'b0, bs.byte_ready}, 32'd1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bs.byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    bs.byte_data  = b;
    bs.byte_valid = 1'b1;
    chk("ready_at_send", {31'b0, bs.byte_ready}, 32'd1);
    @(negedge clk);
    bs.byte_valid = 1'b0;
    bs.byte_data  = 8'($urandom);
  endtask

  task automatic run_frame(input int gap_max);
    foreach (frame_q[k]) send_byte(frame_q[k], $urandom_range(0, gap_max));
  endtask

  task automatic check_frame(input logic exp_done, input logic exp_err);
    int n;
    chk("done",       {31'b0, done},          {31'b0, exp_done});
    chk("error",      {31'b0, error},         {31'b0, exp_err});
    chk("cpu_hold",   {31'b0, cpu_hold},      {31'b0, ~exp_done});
    chk("byte_ready", {31'b0, bs.byte_ready}, {31'b0, ~(exp_done | exp_err)});
    repeat (3) @(negedge clk);
    chk("write_count", got_data.size(), exp_q.size());
    n = (got_data.size() < exp_q.size()) ? got_data.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", got_addr[i], 32'(i * 4));
      chk("wr_data", got_data[i], exp_q[i]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90,
             8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h21, 8'h00,
             8'h00, 8'h00, 8'h00};
    //          off n  gap nw  w0             w1             done  err
    vecs[0] = '{0,  11, 0, 2, 32'h0000_0013, 32'h0010_0093, 1'b1, 1'b0};
    vecs[1] = '{0,  11, 3, 2, 32'h0000_0013, 32'h0010_0093, 1'b1, 1'b0};
    vecs[2] = '{11, 7,  0, 1, 32'h0000_0013, 32'h0,         1'b0, 1'b1};
    vecs[3] = '{18, 2,  0, 0, 32'h0,         32'h0,         1'b0, 1'b1};
    vecs[4] = '{20, 3,  0, 0, 32'h0,         32'h0,         1'b1, 1'b0};

    rst           = 1'b1;
    bs.byte_valid = 1'b0;
    bs.byte_data  = 8'h00;

    // Reset state, one cycle after rst drops
    do_reset();
    @(negedge clk);
    chk("rst_byte_ready", {31'b0, bs.byte_ready}, 32'd1);
    chk("rst_cpu_hold",   {31'b0, cpu_hold},      32'd1);
    chk("rst_wr_en",      {31'b0, wr_en},         32'd0);
    chk("rst_done",       {31'b0, done},          32'd0);
    chk("rst_error",      {31'b0, error},         32'd0);
    chk("rst_wr_addr",    wr_addr,                32'd0);
    chk("rst_wr_data",    wr_data,                32'd0);

    // Directed frame table
    for (int v = 0; v < 5; v++) begin
      do_reset();
      frame_q.delete();
      exp_q.delete();
      for (int k = 0; k < vecs[v].n; k++) frame_q.push_back(stim[vecs[v].off + k]);
      if (vecs[v].nw > 0) exp_q.push_back(vecs[v].w0);
      if (vecs[v].nw > 1) exp_q.push_back(vecs[v].w1);
      run_frame(vecs[v].gap_max);
      check_frame(vecs[v].exp_done, vecs[v].exp_err);
      if (vecs[v].gap_max == 0 && got_cyc.size() == 2)
        chk("write_spacing", got_cyc[1] - got_cyc[0], 32'd4);
    end

    // Reset in the middle of a word, then a fresh frame
    do_reset();
    frame_q = '{8'h01, 8'h00, 8'h13, 8'h00};
    run_frame(0);
    do_reset();
    chk("abort_no_write", got_data.size(), 32'd0);
    frame_q = '{8'h01, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00, 8'h37};
    exp_q   = '{32'h0000_0037};
    run_frame(0);
    check_frame(1'b1, 1'b0);

    // Valid bytes offered after DONE must be ignored
    bs.byte_data  = 8'h55;
    bs.byte_valid = 1'b1;
    repeat (6) @(negedge clk);
    bs.byte_valid = 1'b0;
    chk("post_done_writes", got_data.size(), 32'd1);
    chk("post_done_state",  {31'b0, done},   32'd1);

    // Random frames against a word-list reference model
    for (int it = 0; it < 25; it++) begin
      int         nw;
      logic       corrupt, ok;
      logic [7:0] x;
      logic [31:0] w;
      if (it == 0)                       nw = MEM;
      else if ($urandom_range(0, 9) == 0) nw = $urandom_range(MEM + 1, 65535);
      else                               nw = $urandom_range(0, MEM);
      corrupt = (nw <= MEM) && ($urandom_range(0, 3) == 0);
      do_reset();
      frame_q.delete();
      exp_q.delete();
      frame_q.push_back(nw[7:0]);
      frame_q.push_back(nw[15:8]);
      x = 8'h00;
      if (nw <= MEM) begin
        for (int i = 0; i < nw; i++) begin
          w = $urandom;
          exp_q.push_back(w);
          for (int k = 0; k < 4; k++) begin
            frame_q.push_back(w[8*k +: 8]);
            x = x ^ w[8*k +: 8];
          end
        end
        frame_q.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
      end
      ok = (nw <= MEM) && !corrupt;
      run_frame(3);
      check_frame(ok, !ok);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
